// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS memory-access stage:
// pipeline register layouts, writeback-select codes and byte-lane offsets.
package mem_stage_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // Big-endian lane offsets: offset 0 is the most significant byte.
    localparam logic [1:0] LANE_OFF_B0 = 2'd0;
    localparam logic [1:0] LANE_OFF_B1 = 2'd1;
    localparam logic [1:0] LANE_OFF_B2 = 2'd2;
    localparam logic [1:0] LANE_OFF_B3 = 2'd3;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic regwrite;
        logic memwrite;
        logic memtoreg;
        logic lb;
        logic lbu;
        logic sb;
        logic jal;
        logic jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] inst;
        logic [31:0] aluresult;
        logic [31:0] wdata;
        logic [4:0]  rw;
        ctrl_t       ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] data;
        logic [4:0]  rw;
        logic        regwrite;
    } mem_wb_t;

    function automatic logic [1:0] wb_sel(input ctrl_t c);
        if (c.jal || c.jalr) return WB_SEL_PC4;
        if (c.memtoreg)      return WB_SEL_LOAD;
        return WB_SEL_ALU;
    endfunction

    // Byte-enable bit i covers data bits [8i+7:8i]; offset 0 maps to bit 3.
    function automatic logic [3:0] lane_mask(input logic [1:0] off);
        return 4'b1000 >> off;
    endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: word-addressed array with per-byte write enables.
// Latency: combinational read, write lands at the rising edge.
// Backpressure: none; the caller gates we.
module data_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, byte/word data memory, MEM/WB register.
// Latency: ALU result to mem_fwd 1 cycle; load data to wb_data 2 cycles.
// Backpressure: stall freezes both registers and blocks memory writes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pc_plus4,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_aluresult,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rw,
    input  logic        ex_memtoreg,
    input  logic        ex_regwrite,
    input  logic        ex_memwrite,
    input  logic        ex_lb,
    input  logic        ex_lbu,
    input  logic        ex_sb,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    output logic [4:0]  mem_rw,
    output logic        mem_regwrite,
    output logic [31:0] mem_fwd,
    output logic [4:0]  wb_rw,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_inst,
    output logic        addr_err
);

    ctrl_t   ex_ctrl;
    ex_mem_t ex_mem_d;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_d;
    mem_wb_t mem_wb_q;

    assign ex_ctrl = '{
        regwrite: ex_regwrite,
        memwrite: ex_memwrite,
        memtoreg: ex_memtoreg,
        lb:       ex_lb,
        lbu:      ex_lbu,
        sb:       ex_sb,
        jal:      ex_jal,
        jalr:     ex_jalr
    };

    assign ex_mem_d = '{
        pc:        ex_pc,
        pc_plus4:  ex_pc_plus4,
        inst:      ex_inst,
        aluresult: ex_aluresult,
        wdata:     ex_wdata,
        rw:        ex_rw,
        ctrl:      ex_ctrl
    };

    // A flush clears the whole entry, leaving a bubble with NOP control.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (!stall) begin
            if (flush) begin
                ex_mem_q      <= '0;
                ex_mem_q.ctrl <= CTRL_NOP;
            end else begin
                ex_mem_q <= ex_mem_d;
            end
        end
    end

    ctrl_t         ctl;
    logic [1:0]    byte_off;
    logic [AW-1:0] word_addr;
    logic          byte_op;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    assign ctl       = ex_mem_q.ctrl;
    assign byte_off  = ex_mem_q.aluresult[1:0];
    assign word_addr = ex_mem_q.aluresult[AW+1:2];
    assign byte_op   = ctl.sb | ctl.lb | ctl.lbu;
    assign addr_err  = (ctl.memwrite | ctl.memtoreg) & ~byte_op & (byte_off != 2'b00);
    assign mem_we    = ctl.memwrite & ~addr_err & ~stall & ~rst;
    assign mem_be    = ctl.sb ? lane_mask(byte_off) : 4'hF;
    // Replicating the byte lets the enable mask alone pick the lane.
    assign mem_wdata = ctl.sb ? {4{ex_mem_q.wdata[7:0]}} : ex_mem_q.wdata;

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_addr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    logic [7:0]  lane_byte;
    logic [31:0] load_data;
    logic [31:0] result;

    always_comb begin
        lane_byte = 8'h00;
        case (byte_off)
            LANE_OFF_B0: lane_byte = mem_rdata[31:24];
            LANE_OFF_B1: lane_byte = mem_rdata[23:16];
            LANE_OFF_B2: lane_byte = mem_rdata[15:8];
            LANE_OFF_B3: lane_byte = mem_rdata[7:0];
            default:     lane_byte = 8'h00;
        endcase

        load_data = mem_rdata;
        if (addr_err)     load_data = '0;
        else if (ctl.lb)  load_data = {{24{lane_byte[7]}}, lane_byte};
        else if (ctl.lbu) load_data = {24'h000000, lane_byte};

        result = ex_mem_q.aluresult;
        case (wb_sel(ctl))
            WB_SEL_PC4:  result = ex_mem_q.pc_plus4;
            WB_SEL_LOAD: result = load_data;
            default:     result = ex_mem_q.aluresult;
        endcase
    end

    assign mem_wb_d = '{
        pc:       ex_mem_q.pc,
        inst:     ex_mem_q.inst,
        data:     result,
        rw:       ex_mem_q.rw,
        regwrite: ctl.regwrite
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_q <= '0;
        end else if (!stall) begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_rw       = ex_mem_q.rw;
    assign mem_regwrite = ctl.regwrite;
    assign mem_fwd      = ex_mem_q.aluresult;
    assign wb_rw        = mem_wb_q.rw;
    assign wb_regwrite  = mem_wb_q.regwrite;
    assign wb_data      = mem_wb_q.data;
    assign wb_pc        = mem_wb_q.pc;
    assign wb_inst      = mem_wb_q.inst;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed scenarios then randomized traffic
// against a program-order memory model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int OP_ALU = 0, OP_LW = 1, OP_LB = 2, OP_LBU = 3;
    localparam int OP_SW  = 4, OP_SB = 5, OP_JAL = 6, OP_JALR = 7;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] ex_pc, ex_pc_plus4, ex_inst, ex_aluresult, ex_wdata;
    logic [4:0]  ex_rw;
    logic        ex_memtoreg, ex_regwrite, ex_memwrite, ex_lb, ex_lbu, ex_sb, ex_jal, ex_jalr;
    logic [4:0]  mem_rw, wb_rw;
    logic        mem_regwrite, wb_regwrite, addr_err;
    logic [31:0] mem_fwd, wb_data, wb_pc, wb_inst;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4), .ex_inst(ex_inst),
        .ex_aluresult(ex_aluresult), .ex_wdata(ex_wdata), .ex_rw(ex_rw),
        .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
        .ex_lb(ex_lb), .ex_lbu(ex_lbu), .ex_sb(ex_sb), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .mem_rw(mem_rw), .mem_regwrite(mem_regwrite), .mem_fwd(mem_fwd),
        .wb_rw(wb_rw), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .wb_pc(wb_pc), .wb_inst(wb_inst), .addr_err(addr_err)
    );

    typedef struct {
        logic [31:0] pc, inst, alu, data, cval;
        logic [4:0]  rw;
        logic        regwrite, aerr, cchk;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ctrl(input int op);
        ex_regwrite = op inside {OP_ALU, OP_LW, OP_LB, OP_LBU, OP_JAL, OP_JALR};
        ex_memtoreg = op inside {OP_LW, OP_LB, OP_LBU};
        ex_memwrite = op inside {OP_SW, OP_SB};
        ex_lb   = (op == OP_LB);
        ex_lbu  = (op == OP_LBU);
        ex_sb   = (op == OP_SB);
        ex_jal  = (op == OP_JAL);
        ex_jalr = (op == OP_JALR);
    endtask

    task automatic rand_inputs();
        ex_pc = $urandom; ex_pc_plus4 = $urandom; ex_inst = $urandom;
        ex_aluresult = $urandom; ex_wdata = $urandom; ex_rw = 5'($urandom);
        set_ctrl($urandom_range(0, 7));
    endtask

    // Present one instruction on an unstalled cycle and record what WB must show.
    task automatic drive(input int op, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rw, input logic [31:0] pc, input bit fl,
                         input bit cchk, input logic [31:0] cval);
        exp_t        e;
        int          idx, off, sh;
        logic [31:0] bv;
        stall = 1'b0; flush = fl;
        ex_pc = pc; ex_pc_plus4 = pc + 32'd4; ex_inst = $urandom;
        ex_aluresult = alu; ex_wdata = wd; ex_rw = rw;
        set_ctrl(op);
        e = '{default: '0};
        if (!fl) begin
            idx = int'((alu >> 2) % DEPTH);
            off = int'(alu % 4);
            sh  = 8 * (3 - off);
            e.aerr = (op inside {OP_LW, OP_SW}) && (off != 0);
            bv = (op inside {OP_LB, OP_LBU}) ? ((mm[idx] >> sh) & 32'hFF) : 32'h0;
            if (op == OP_SW && !e.aerr) mm[idx] = wd;
            if (op == OP_SB) mm[idx] = (mm[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            case (op)
                OP_JAL, OP_JALR: e.data = pc + 32'd4;
                OP_LW:           e.data = e.aerr ? 32'h0 : mm[idx];
                OP_LB:           e.data = (bv >= 32'h80) ? (bv | 32'hFFFFFF00) : bv;
                OP_LBU:          e.data = bv;
                default:         e.data = alu;
            endcase
            e.pc = pc; e.inst = ex_inst; e.alu = alu; e.rw = rw;
            e.regwrite = ex_regwrite;
        end
        e.cchk = cchk; e.cval = cval;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic stall_cyc(input bit fl);
        stall = 1'b1; flush = fl;
        rand_inputs();
        @(posedge clk); #1;
    endtask

    task automatic reset_and_check();
        exp_t z;
        mon_en = 0;
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        rand_inputs();
        ex_regwrite = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_rw", 32'(mem_rw), 0);
        check("rst_mem_regwrite", 32'(mem_regwrite), 0);
        check("rst_mem_fwd", mem_fwd, 0);
        check("rst_wb_rw", 32'(wb_rw), 0);
        check("rst_wb_regwrite", 32'(wb_regwrite), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_wb_inst", wb_inst, 0);
        check("rst_addr_err", 32'(addr_err), 0);
        rst = 1'b0;
        z = '{default: '0};
        q.delete();
        q.push_back(z);
        mon_en = 1;
    endtask

    // Monitor: every unstalled edge retires the oldest entry into WB; the next is in MEM.
    initial begin
        bit   shifted;
        exp_t e;
        forever begin
            @(posedge clk);
            shifted = mon_en && !stall && !rst;
            @(negedge clk);
            if (mon_en) begin
                if (shifted) begin
                    if (q.size() < 2) begin
                        n_tests++; n_fail++;
                        $display("FAIL scoreboard_empty: got %0d entries required 2", q.size());
                    end else begin
                        e = q.pop_front();
                        check("wb_rw", 32'(wb_rw), 32'(e.rw));
                        check("wb_regwrite", 32'(wb_regwrite), 32'(e.regwrite));
                        check("wb_data", wb_data, e.data);
                        check("wb_pc", wb_pc, e.pc);
                        check("wb_inst", wb_inst, e.inst);
                        if (e.cchk) check("wb_data_const", wb_data, e.cval);
                    end
                end
                if (q.size() > 0) begin
                    check("mem_rw", 32'(mem_rw), 32'(q[0].rw));
                    check("mem_regwrite", 32'(mem_regwrite), 32'(q[0].regwrite));
                    check("mem_fwd", mem_fwd, q[0].alu);
                    check("addr_err", 32'(addr_err), 32'(q[0].aerr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int          op, w, off;
        logic [31:0] alu;
        reset_and_check();

        drive(OP_SW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h00400000, 0, 0, 0);
        drive(OP_LW, 32'h10, 32'h0, 5'd9, 32'h00400004, 0, 1, 32'hDEADBEEF);

        drive(OP_SW,  32'h20, 32'h11223344, 5'd0, 32'h00400010, 0, 0, 0);
        drive(OP_SB,  32'h22, 32'h000000AA, 5'd0, 32'h00400014, 0, 0, 0);
        drive(OP_LW,  32'h20, 32'h0, 5'd2, 32'h00400018, 0, 1, 32'h1122AA44);
        drive(OP_LB,  32'h22, 32'h0, 5'd3, 32'h0040001C, 0, 1, 32'hFFFFFFAA);
        drive(OP_LBU, 32'h22, 32'h0, 5'd4, 32'h00400020, 0, 1, 32'h000000AA);

        drive(OP_LW, 32'h21, 32'h0, 5'd5, 32'h00400024, 0, 1, 32'h0);
        drive(OP_SW, 32'h21, 32'h55, 5'd0, 32'h00400028, 0, 0, 0);
        drive(OP_LW, 32'h20, 32'h0, 5'd6, 32'h0040002C, 0, 1, 32'h1122AA44);

        drive(OP_JAL, 32'h1234, 32'h0, REG_RA, 32'h00400004, 0, 1, 32'h00400008);

        drive(OP_SW, 32'h30, 32'h12345678, 5'd0, 32'h00400030, 0, 0, 0);
        drive(OP_SW, 32'h30, 32'hCAFEF00D, 5'd0, 32'h00400034, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            stall_cyc(i == 1);
            check("stalled_store_held", dut.u_dmem.mem[12], 32'h12345678);
        end
        drive(OP_ALU, 32'h77, 32'h0, 5'd7, 32'h00400038, 0, 0, 0);
        check("store_after_release", dut.u_dmem.mem[12], 32'hCAFEF00D);
        drive(OP_LW, 32'h30, 32'h0, 5'd8, 32'h0040003C, 0, 1, 32'hCAFEF00D);

        drive(OP_ALU, 32'h99, 32'h0, 5'd10, 32'h00400040, 1, 0, 0);
        drive(OP_SW, 32'h20, 32'hFFFFFFFF, 5'd0, 32'h00400044, 1, 0, 0);
        drive(OP_LW, 32'h20, 32'h0, 5'd11, 32'h00400048, 0, 1, 32'h1122AA44);
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 32'h0040004C, 0, 0, 0);

        reset_and_check();
        drive(OP_LW, 32'h10, 32'h0, 5'd12, 32'h00400050, 0, 1, 32'hDEADBEEF);

        for (int i = 0; i < 16; i++)
            drive(OP_SW, 32'h100 + 32'(i * 4), $urandom, 5'd0, $urandom & 32'hFFFFFFFC, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 2) stall_cyc(1'($urandom_range(0, 1)));
            op  = $urandom_range(0, 7);
            w   = $urandom_range(0, 15);
            off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
            if (op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB})
                alu = ($urandom & 32'hFFFFF000) | 32'h100 | 32'(w * 4) | 32'(off);
            else
                alu = $urandom;
            drive(op, alu, $urandom, 5'($urandom), $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 9) == 0, 0, 0);
        end

        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 0);
        drive(OP_ALU, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 0);
        stall = 1'b1;
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
